// File: rtl/inst_buffer.sv
// inst_buffer: fetch-side instruction queue between IF and decode.
// Circular buffer of {inst, pc} with wrap-bit pointers, valid/ready on both sides,
// single-cycle flush. Optional same-cycle bypass on an empty buffer when the
// IBUF_BYPASS_EN macro is defined; the default build has no bypass.

`ifndef XLEN
`define XLEN 32
`endif

module inst_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         if_valid,
  input  logic [31:0]                  if_inst,
  input  logic [`XLEN-1:0]             if_pc,
  output logic                         if_ready,
  input  logic                         flush,
  input  logic                         dec_ready,
  output logic                         out_valid,
  output logic [31:0]                  out_inst,
  output logic [`XLEN-1:0]             out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]       inst_mem [DEPTH];
  logic [`XLEN-1:0]  pc_mem   [DEPTH];

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [IdxW-1:0]   head_idx;
  logic [IdxW-1:0]   tail_idx;
  logic              empty;
  logic              full;
  logic              bypass;
  logic              stored_valid;
  logic              enq;
  logic              deq;

  assign head_idx = head_q[IdxW-1:0];
  assign tail_idx = tail_q[IdxW-1:0];
  assign count    = count_q;

  // Status, handshakes and head presentation.
  always_comb begin
    empty = (head_q == tail_q);
    full  = (head_idx == tail_idx) && (head_q[IdxW] != tail_q[IdxW]);
    // if_ready depends only on registered state plus flush/reset, never on dec_ready.
    if_ready = !full && !flush && !reset;
`ifdef IBUF_BYPASS_EN
    bypass = empty && if_valid && !flush && !reset;
`else
    bypass = 1'b0;
`endif
    stored_valid = !empty && !flush;
    out_valid    = stored_valid || bypass;
    out_inst     = 32'h0;
    out_pc       = '0;
    if (stored_valid) begin
      out_inst = inst_mem[head_idx];
      out_pc   = pc_mem[head_idx];
    end else if (bypass) begin
      out_inst = if_inst;
      out_pc   = if_pc;
    end
    // A bypassed instruction taken by decode is never written.
    enq = if_valid && if_ready && !(bypass && dec_ready);
    deq = stored_valid && dec_ready;
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PtrW'(1);
      if (deq) head_d = head_q + PtrW'(1);
      if (enq && !deq) begin
        count_d = count_q + CntW'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care once pointers are reset.
  always_ff @(posedge clock) begin
    if (enq) begin
      inst_mem[tail_idx] <= if_inst;
      pc_mem[tail_idx]   <= if_pc;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer: directed vectors with a scoreboard of expected PCs.
// Stimulus pushes each instruction it expects to be accepted; a negedge monitor
// compares the presented head against the queue front and pops on consumption.

`ifndef XLEN
`define XLEN 32
`endif

module tb_inst_buffer;

  localparam int unsigned DEPTH = 8;

  logic               clock;
  logic               reset;
  logic               if_valid;
  logic [31:0]        if_inst;
  logic [`XLEN-1:0]   if_pc;
  logic               if_ready;
  logic               flush;
  logic               dec_ready;
  logic               out_valid;
  logic [31:0]        out_inst;
  logic [`XLEN-1:0]   out_pc;
  logic [3:0]         count;

  int checks = 0;
  int errors = 0;
  logic [`XLEN-1:0] sb[$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .if_ready  (if_ready),
    .flush     (flush),
    .dec_ready (dec_ready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [`XLEN-1:0] pc);
    return 32'hA500_0000 ^ 32'(pc);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [`XLEN-1:0] pc, input logic dr,
                       input logic fl);
    if_valid  = v;
    if_pc     = pc;
    if_inst   = inst_of(pc);
    dec_ready = dr;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare head against scoreboard, pop when decode consumes it.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %0h expected no valid output at %0t",
                   out_pc, $time);
        end else begin
          chk("head_pc", 64'(out_pc), 64'(sb[0]));
          chk("head_inst", 64'(out_inst), 64'(inst_of(sb[0])));
          if (dec_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_pc", 64'(out_pc), 64'h0);
        chk("idle_inst", 64'(out_inst), 64'h0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_if_ready", 64'(if_ready), 64'd1);
    step();

    // Fill to full with decode stalled
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, `XLEN'(4 * i), 1'b0, 1'b0);
      sb.push_back(`XLEN'(4 * i));
      step();
      chk("fill_count", 64'(count), 64'(i + 1));
    end
    chk("full_if_ready", 64'(if_ready), 64'd0);
    drive(1'b1, `XLEN'('h20), 1'b0, 1'b0);
    #1;
    chk("ninth_if_ready", 64'(if_ready), 64'd0);
    step();
    chk("ninth_count", 64'(count), 64'd8);

    // Drain in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
      chk("drain_count", 64'(count), 64'(7 - i));
    end
    chk("drained_out_valid", 64'(out_valid), 64'd0);
    chk("drained_out_inst", 64'(out_inst), 64'd0);
    chk("drained_sb", 64'(sb.size()), 64'd0);

    // Concurrent enqueue/dequeue across pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, `XLEN'('h100 + 4 * i), 1'b0, 1'b0);
      sb.push_back(`XLEN'('h100 + 4 * i));
      step();
    end
    chk("hold3_count", 64'(count), 64'd3);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, `XLEN'('h10C + 4 * i), 1'b1, 1'b0);
      sb.push_back(`XLEN'('h10C + 4 * i));
      step();
      chk("conc_count", 64'(count), 64'd3);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    chk("conc_drained_count", 64'(count), 64'd0);
    chk("conc_drained_sb", 64'(sb.size()), 64'd0);

    // Full with dec_ready=1: dequeue only
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, `XLEN'('h200 + 4 * i), 1'b0, 1'b0);
      sb.push_back(`XLEN'('h200 + 4 * i));
      step();
    end
    chk("full2_count", 64'(count), 64'd8);
    drive(1'b1, `XLEN'('h300), 1'b1, 1'b0);
    #1;
    chk("full2_if_ready", 64'(if_ready), 64'd0);
    step();
    chk("full2_deq_count", 64'(count), 64'd7);
    chk("full2_if_ready_next", 64'(if_ready), 64'd1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    chk("full2_drained_count", 64'(count), 64'd0);
    chk("full2_drained_sb", 64'(sb.size()), 64'd0);

    // Flush with a same-cycle enqueue, then held for two more cycles
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, `XLEN'('h400 + 4 * i), 1'b0, 1'b0);
      sb.push_back(`XLEN'('h400 + 4 * i));
      step();
    end
    chk("pre_flush_count", 64'(count), 64'd5);
    drive(1'b1, `XLEN'('h40), 1'b1, 1'b1);
    sb.delete();
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_if_ready", 64'(if_ready), 64'd0);
    step();
    chk("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("flush_hold_if_ready", 64'(if_ready), 64'd0);
      step();
      chk("flush_hold_count", 64'(count), 64'd0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("post_flush_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-fill
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, `XLEN'('h500 + 4 * i), 1'b0, 1'b0);
      sb.push_back(`XLEN'('h500 + 4 * i));
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_pc", 64'(out_pc), 64'd0);
    chk("mid_rst_if_ready", 64'(if_ready), 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_release_if_ready", 64'(if_ready), 64'd1);
    step();

    // Empty buffer, single instruction with decode ready
    drive(1'b1, `XLEN'('h80), 1'b1, 1'b0);
    sb.push_back(`XLEN'('h80));
    #1;
`ifdef IBUF_BYPASS_EN
    chk("byp_out_valid", 64'(out_valid), 64'd1);
    chk("byp_out_pc", 64'(out_pc), 64'h80);
    step();
    chk("byp_count", 64'(count), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
`else
    chk("nobyp_out_valid", 64'(out_valid), 64'd0);
    step();
    chk("nobyp_count", 64'(count), 64'd1);
    chk("nobyp_out_pc", 64'(out_pc), 64'h80);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
`endif
    chk("final_count", 64'(count), 64'd0);
    chk("final_sb", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
